image_frame_buffer: RTL and testbench
=====================================

Name: image_frame_buffer

Overview:
- Parametrised on-chip image memory for the Nios image path.
- Port A is an Avalon-MM slave for CPU/JTAG load and readback.
- Port B is an autonomous scanner that streams a programmed address window out on an Avalon-ST source with ready/valid backpressure.
- Downstream video/processing blocks take image data from the stream instead of polling the CPU bus.

Parameters:
- DATA_W, 8, pixel/word width in bits; must be a multiple of 8.
- ADDR_W, 16, word-address width.
- DEPTH, 65536, number of words; must be ≤ 2^ADDR_W.
- INIT_FILE, "ImagemB.mif", memory initialisation file.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- s_address  in  ADDR_W  Avalon-MM word address.
- s_chipselect  in  1  slave select.
- s_read  in  1  read request.
- s_write  in  1  write request.
- s_writedata  in  DATA_W  write data.
- s_byteenable  in  DATA_W/8  byte lane enables for writes.
- s_readdata  out  DATA_W  read data.
- s_readdatavalid  out  1  read data qualifier.
- wr_enable  in  1  global write permit; when low, writes are dropped.
- scan_start  in  1  one-cycle pulse that starts a scan.
- scan_base  in  ADDR_W  first word address of the scan.
- scan_len  in  ADDR_W+1  number of words to stream (0..DEPTH).
- scan_busy  out  1  high while a scan is active.
- scan_done  out  1  one-cycle pulse after the last beat is accepted.
- st_data  out  DATA_W  stream data.
- st_valid  out  1  stream valid.
- st_ready  in  1  downstream ready.
- st_sop  out  1  first beat of a scan.
- st_eop  out  1  last beat of a scan.

Behaviour:
- Reset: all outputs are 0. Scanner returns to IDLE and the skid buffer empties. Memory contents are not cleared.
- Reset mid-scan aborts the scan immediately. No done pulse is generated.

Port A (Avalon-MM slave):
- No waitrequest.
- Read accepted at cycle N (chipselect & read) → s_readdatavalid=1 with s_readdata at N+1, exactly one cycle. Pipelined back-to-back reads give one result per cycle.
- Write at N (chipselect & write & wr_enable) updates only the enabled byte lanes.
- Read-after-write to the same address on a later cycle returns the new data.
- Simultaneous read and write on port A: the write wins, and no readdatavalid is produced.
- Addresses ≥ DEPTH: reads return 0 with readdatavalid; writes are ignored.

Scanner FSM:
- States: IDLE, RUN, DRAIN.
- IDLE:
  - scan_start with scan_len>0 → latch base/len, set scan_busy, enter RUN.
  - scan_start with scan_len=0 → scan_done pulse next cycle, no beats, stay IDLE.
- RUN:
  - Issues one port-B read per cycle while (skid occupancy + reads in flight) < 2. The RAM latency is 1 cycle.
  - Read address = (base + issued) mod DEPTH, so the window wraps at DEPTH-1 → 0.
  - After the last read is issued → DRAIN.
- DRAIN: when the eop beat is accepted (st_valid & st_ready) → scan_done pulse, scan_busy=0, return to IDLE.
- scan_start while busy is ignored.

Stream source:
- 2-entry skid FIFO. st_data/st_valid come from the FIFO head.
- st_data is held stable while st_valid & !st_ready.
- With st_ready held high, throughput is 1 beat/cycle; first beat st_valid is 2 cycles after scan_start.
- st_sop marks beat 0 and st_eop marks beat len-1. len=1 asserts both on the same beat.

Port-B read-during-write:
- A port-A write to the address port B reads in the same cycle → port B returns the OLD data.

Decomposition:
- Package image_fb_pkg: scanner state enum (IDLE/RUN/DRAIN) and a clog2 helper.
- Sub-module image_fb_ram: simple dual-port RAM. Port A read/write with byte enables, port B read-only. Registered address, old-data read-during-write, INIT_FILE load.
- Top level holds the slave decode, the scanner FSM and the skid FIFO.

Test Plan:
1. Write 0xA5 to address 0x0010 with byteenable=1, then read address 0x0010 → readdata=0xA5 with readdatavalid exactly one cycle after the read. Repeat with wr_enable=0 writing 0x3C → readback is still 0xA5.
2. Preload 0..15 at addresses 0..15; scan base=0, len=16, st_ready=1 → 16 consecutive beats 0..15. sop on beat 0, eop on beat 15, scan_done one cycle after the eop handshake.
3. Same scan with st_ready toggling in a random 1/0 pattern → same data sequence, no lost or duplicated beats, st_data stable whenever stalled.
4. Wrap: base=0xFFFE, len=4 → addresses FFFE, FFFF, 0000, 0001 streamed in that order.
5. Edge cases:
   - len=0 → scan_done pulse with st_valid never asserted.
   - len=1 → one beat with sop=eop=1.
   - scan_start during busy → ignored.
6. Assert reset_n low mid-scan at beat 5 of 16 → all outputs 0 asynchronously, no scan_done. A new scan after release streams correctly from beat 0.

Source files
------------

// File: rtl/image_fb_pkg.sv
// Shared types and helpers for the image frame buffer: scanner states and a
// constant-foldable ceil(log2) used to size the RAM address.
package image_fb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } scan_state_t;

    // Returns at least 1 so a single-word memory still gets a 1-bit address.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/image_fb_ram.sv
// Simple dual-port image RAM: port A read/write with byte lanes, port B read-only.
// Both read ports are registered and return the pre-write word on an address collision.
module image_fb_ram #(
    parameter int DATA_W    = 8,
    parameter int AW        = 16,
    parameter int DEPTH     = 65536,
    parameter     INIT_FILE = "ImagemB.mif"
) (
    input  logic                clk,
    input  logic [AW-1:0]       addr_a,
    input  logic                we_a,
    input  logic [DATA_W/8-1:0] be_a,
    input  logic [DATA_W-1:0]   wdata_a,
    output logic [DATA_W-1:0]   rdata_a,
    input  logic [AW-1:0]       addr_b,
    output logic [DATA_W-1:0]   rdata_b
);
    localparam int LANES = DATA_W / 8;

    (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we_a) begin
            for (int i = 0; i < LANES; i++) begin
                if (be_a[i]) mem[addr_a][i*8 +: 8] <= wdata_a[i*8 +: 8];
            end
        end
        rdata_a <= mem[addr_a];
        rdata_b <= mem[addr_b];
    end

endmodule

// File: rtl/image_frame_buffer.sv
// On-chip image memory: Avalon-MM slave on port A, and a window scanner on
// port B that streams words out through a 2-entry skid FIFO with ready/valid.
module image_frame_buffer
    import image_fb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 65536,
    parameter     INIT_FILE = "ImagemB.mif"
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   s_address,
    input  logic                s_chipselect,
    input  logic                s_read,
    input  logic                s_write,
    input  logic [DATA_W-1:0]   s_writedata,
    input  logic [DATA_W/8-1:0] s_byteenable,
    output logic [DATA_W-1:0]   s_readdata,
    output logic                s_readdatavalid,
    input  logic                wr_enable,
    input  logic                scan_start,
    input  logic [ADDR_W-1:0]   scan_base,
    input  logic [ADDR_W:0]     scan_len,
    output logic                scan_busy,
    output logic                scan_done,
    output logic [DATA_W-1:0]   st_data,
    output logic                st_valid,
    input  logic                st_ready,
    output logic                st_sop,
    output logic                st_eop
);
    localparam int AW = clog2(DEPTH);
    localparam int LW = ADDR_W + 1;
    localparam logic [LW-1:0] DEPTH_W   = LW'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [DATA_W-1:0] ram_rdata_a, ram_rdata_b;
    logic [AW-1:0]     b_addr, start_addr;
    logic              a_oob, a_write_req, a_read_req, a_we;
    logic              rd_valid_reg, rd_oob_reg;

    scan_state_t       state_reg, state_next;
    logic [AW-1:0]     rd_addr_reg, rd_addr_next;
    logic [LW-1:0]     remain_reg, remain_next;
    logic              inflight_reg, inflight_sop_reg, inflight_eop_reg;
    logic              done_reg, done_next;
    logic              issue, issue_sop, issue_eop;

    logic              wr_ptr_reg, rd_ptr_reg;
    logic [1:0]        count_reg, occupancy;
    logic              push, pop, room;
    logic [DATA_W-1:0] head_data;
    logic              head_sop, head_eop;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + AW'(1);
    endfunction

    // Port A: a write request always takes the cycle, so a concurrent read is dropped.
    assign a_oob       = {1'b0, s_address} >= DEPTH_W;
    assign a_write_req = s_chipselect & s_write;
    assign a_read_req  = s_chipselect & s_read & ~a_write_req;
    assign a_we        = a_write_req & wr_enable & ~a_oob;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_reg <= 1'b0;
            rd_oob_reg   <= 1'b0;
        end else begin
            rd_valid_reg <= a_read_req;
            rd_oob_reg   <= a_oob;
        end
    end

    assign s_readdatavalid = rd_valid_reg;
    assign s_readdata      = (rd_valid_reg & ~rd_oob_reg) ? ram_rdata_a : '0;

    image_fb_ram #(
        .DATA_W   (DATA_W),
        .AW       (AW),
        .DEPTH    (DEPTH),
        .INIT_FILE(INIT_FILE)
    ) u_ram (
        .clk    (clk),
        .addr_a (s_address[AW-1:0]),
        .we_a   (a_we),
        .be_a   (s_byteenable),
        .wdata_a(s_writedata),
        .rdata_a(ram_rdata_a),
        .addr_b (b_addr),
        .rdata_b(ram_rdata_b)
    );

    // The first read is issued in the start cycle itself, which gives the 2-cycle first-beat latency.
    assign start_addr = AW'({1'b0, scan_base} % DEPTH_W);
    assign occupancy  = count_reg + {1'b0, inflight_reg} - {1'b0, pop};
    assign room       = occupancy < 2'd2;

    always_comb begin
        state_next   = state_reg;
        rd_addr_next = rd_addr_reg;
        remain_next  = remain_reg;
        done_next    = 1'b0;
        issue        = 1'b0;
        issue_sop    = 1'b0;
        issue_eop    = 1'b0;
        b_addr       = rd_addr_reg;
        case (state_reg)
            IDLE: begin
                if (scan_start) begin
                    if (scan_len == '0) begin
                        done_next = 1'b1;
                    end else begin
                        issue        = 1'b1;
                        issue_sop    = 1'b1;
                        b_addr       = start_addr;
                        rd_addr_next = wrap_inc(start_addr);
                        remain_next  = scan_len - LW'(1);
                        if (scan_len == LW'(1)) begin
                            issue_eop  = 1'b1;
                            state_next = DRAIN;
                        end else begin
                            state_next = RUN;
                        end
                    end
                end
            end
            RUN: begin
                if (room) begin
                    issue        = 1'b1;
                    rd_addr_next = wrap_inc(rd_addr_reg);
                    remain_next  = remain_reg - LW'(1);
                    if (remain_reg == LW'(1)) begin
                        issue_eop  = 1'b1;
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && head_eop) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            rd_addr_reg      <= '0;
            remain_reg       <= '0;
            inflight_reg     <= 1'b0;
            inflight_sop_reg <= 1'b0;
            inflight_eop_reg <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            rd_addr_reg      <= rd_addr_next;
            remain_reg       <= remain_next;
            inflight_reg     <= issue;
            inflight_sop_reg <= issue_sop;
            inflight_eop_reg <= issue_eop;
            done_reg         <= done_next;
        end
    end

    // Skid FIFO: each RAM result lands one cycle after issue; the issue throttle keeps it from overflowing.
    assign push = inflight_reg;
    assign pop  = st_valid & st_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [DATA_W-1:0] data_reg;
            logic              sop_reg, eop_reg;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    data_reg <= '0;
                    sop_reg  <= 1'b0;
                    eop_reg  <= 1'b0;
                end else if (push && wr_ptr_reg == 1'(gi)) begin
                    data_reg <= ram_rdata_b;
                    sop_reg  <= inflight_sop_reg;
                    eop_reg  <= inflight_eop_reg;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_data = rd_ptr_reg ? g_fifo[1].data_reg : g_fifo[0].data_reg;
    assign head_sop  = rd_ptr_reg ? g_fifo[1].sop_reg  : g_fifo[0].sop_reg;
    assign head_eop  = rd_ptr_reg ? g_fifo[1].eop_reg  : g_fifo[0].eop_reg;

    assign st_valid  = count_reg != 2'd0;
    assign st_data   = head_data;
    assign st_sop    = st_valid & head_sop;
    assign st_eop    = st_valid & head_eop;
    assign scan_busy = state_reg != IDLE;
    assign scan_done = done_reg;

endmodule

// File: tb/tb_image_frame_buffer.sv
// Self-checking bench for image_frame_buffer: randomized port-A traffic and scans
// checked against a plain array model of memory and the stream/window rules.
module tb_image_frame_buffer;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 65536;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] s_address;
    logic              s_chipselect, s_read, s_write;
    logic [DATA_W-1:0] s_writedata;
    logic [0:0]        s_byteenable;
    logic [DATA_W-1:0] s_readdata;
    logic              s_readdatavalid;
    logic              wr_enable;
    logic              scan_start;
    logic [ADDR_W-1:0] scan_base;
    logic [ADDR_W:0]   scan_len;
    logic              scan_busy, scan_done;
    logic [DATA_W-1:0] st_data;
    logic              st_valid, st_ready, st_sop, st_eop;

    always #5 clk = ~clk;

    image_frame_buffer dut (
        .clk(clk), .reset_n(reset_n),
        .s_address(s_address), .s_chipselect(s_chipselect), .s_read(s_read),
        .s_write(s_write), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .wr_enable(wr_enable), .scan_start(scan_start), .scan_base(scan_base),
        .scan_len(scan_len), .scan_busy(scan_busy), .scan_done(scan_done),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
        .st_sop(st_sop), .st_eop(st_eop)
    );

    logic [7:0] ref_mem [0:DEPTH-1];
    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] got_data [$];
    bit         got_sop  [$];
    bit         got_eop  [$];
    int first_valid_cyc, eop_hs_cyc, done_cyc, done_count, stall_err, busy_at1, busy_at_done;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic avl_write(input logic [15:0] addr, input logic [7:0] data,
                             input logic be, input logic en);
        s_chipselect = 1; s_write = 1; s_read = 0;
        s_address = addr; s_writedata = data; s_byteenable = be; wr_enable = en;
        step;
        s_chipselect = 0; s_write = 0; wr_enable = 1;
        if (en && be) ref_mem[addr] = data;
    endtask

    task automatic avl_read(input logic [15:0] addr, output logic valid,
                            output logic [7:0] data, output logic valid_after);
        s_chipselect = 1; s_read = 1; s_write = 0; s_address = addr;
        step;
        valid = s_readdatavalid; data = s_readdata;
        s_chipselect = 0; s_read = 0;
        step;
        valid_after = s_readdatavalid;
    endtask

    // Drives one scan and records every accepted beat plus timing relative to the start cycle.
    task automatic run_scan(input logic [15:0] base, input logic [16:0] len,
                            input bit random_ready, input bit inject);
        logic [7:0] prev_data;
        bit prev_stall;
        got_data.delete(); got_sop.delete(); got_eop.delete();
        first_valid_cyc = -1; eop_hs_cyc = -1; done_cyc = -1; done_count = 0;
        stall_err = 0; busy_at1 = -1; busy_at_done = -1;
        prev_stall = 0; prev_data = '0;
        scan_base = base; scan_len = len; scan_start = 1;
        for (int c = 0; c < 3000; c++) begin
            st_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inject && c == 3) begin
                scan_start = 1; scan_base = base + 16'h0100; scan_len = 17'd5;
            end
            #1;
            if (prev_stall && st_data !== prev_data) stall_err++;
            if (st_valid && first_valid_cyc < 0) first_valid_cyc = c;
            if (c == 1) busy_at1 = int'(scan_busy);
            if (scan_done) begin
                done_count++;
                if (done_cyc < 0) begin done_cyc = c; busy_at_done = int'(scan_busy); end
            end
            if (st_valid && st_ready) begin
                got_data.push_back(st_data); got_sop.push_back(st_sop); got_eop.push_back(st_eop);
                if (st_eop && eop_hs_cyc < 0) eop_hs_cyc = c;
            end
            prev_stall = st_valid && !st_ready;
            prev_data  = st_data;
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
            @(posedge clk);
            #1;
            scan_start = 0;
            s_chipselect = 0; s_write = 0; s_read = 0;
        end
        scan_start = 0;
        st_ready = 1;
    endtask

    task automatic test_reset;
        reset_n = 0;
        s_address = '0; s_chipselect = 0; s_read = 0; s_write = 0; s_writedata = '0;
        s_byteenable = 1; wr_enable = 1; scan_start = 0; scan_base = '0; scan_len = '0;
        st_ready = 1;
        step; step;
        n_cmp++;
        if ({s_readdata, s_readdatavalid, scan_busy, scan_done, st_data, st_valid, st_sop, st_eop} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %0h required 0",
                     {s_readdata, s_readdatavalid, scan_busy, scan_done, st_data, st_valid, st_sop, st_eop});
        end
        reset_n = 1;
        step; step;
        n_cmp++;
        if ({s_readdatavalid, scan_busy, scan_done, st_valid} !== 4'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: got %b required 0000",
                     {s_readdatavalid, scan_busy, scan_done, st_valid});
        end
    endtask

    task automatic test_port_a;
        logic v, va;
        logic [7:0] d;
        logic [15:0] addrs [8];
        logic [7:0] wd;
        avl_write(16'h0010, 8'hA5, 1'b1, 1'b1);
        avl_read(16'h0010, v, d, va);
        n_cmp++;
        if (v !== 1'b1 || d !== 8'hA5) begin
            n_err++;
            $display("FAIL read_a5: got valid=%b data=%0h required valid=1 data=a5", v, d);
        end
        n_cmp++;
        if (va !== 1'b0) begin
            n_err++;
            $display("FAIL rdv_one_cycle: got %b required 0", va);
        end
        avl_write(16'h0010, 8'h3C, 1'b1, 1'b0);
        avl_read(16'h0010, v, d, va);
        n_cmp++;
        if (d !== 8'hA5) begin
            n_err++;
            $display("FAIL wr_enable_low: got %0h required a5", d);
        end
        avl_write(16'h0010, 8'h77, 1'b0, 1'b1);
        avl_read(16'h0010, v, d, va);
        n_cmp++;
        if (d !== ref_mem[16'h0010]) begin
            n_err++;
            $display("FAIL byteenable_off: got %0h required %0h", d, ref_mem[16'h0010]);
        end
        for (int i = 0; i < 8; i++) begin
            addrs[i] = 16'h1000 + 16'($urandom_range(0, 255));
            avl_write(addrs[i], 8'($urandom), 1'b1, 1'b1);
        end
        // Back-to-back reads: one address per cycle, one result per cycle.
        s_chipselect = 1; s_read = 1;
        for (int i = 0; i < 8; i++) begin
            s_address = addrs[i];
            step;
            n_cmp++;
            if (s_readdatavalid !== 1'b1 || s_readdata !== ref_mem[addrs[i]]) begin
                n_err++;
                $display("FAIL pipelined_read[%0d]: got valid=%b data=%0h required valid=1 data=%0h",
                         i, s_readdatavalid, s_readdata, ref_mem[addrs[i]]);
            end
        end
        s_chipselect = 0; s_read = 0;
        step;
        n_cmp++;
        if (s_readdatavalid !== 1'b0) begin
            n_err++;
            $display("FAIL pipelined_tail: got %b required 0", s_readdatavalid);
        end
        wd = 8'($urandom);
        s_chipselect = 1; s_read = 1; s_write = 1; wr_enable = 1;
        s_address = 16'h0020; s_writedata = wd; s_byteenable = 1;
        step;
        n_cmp++;
        if (s_readdatavalid !== 1'b0) begin
            n_err++;
            $display("FAIL rw_collision_valid: got %b required 0", s_readdatavalid);
        end
        ref_mem[16'h0020] = wd;
        s_chipselect = 0; s_read = 0; s_write = 0;
        avl_read(16'h0020, v, d, va);
        n_cmp++;
        if (d !== wd) begin
            n_err++;
            $display("FAIL rw_collision_write: got %0h required %0h", d, wd);
        end
    endtask

    task automatic test_stream;
        for (int i = 0; i < 16; i++) avl_write(16'(i), 8'(i), 1'b1, 1'b1);
        for (int mode = 0; mode < 2; mode++) begin
            run_scan(16'h0000, 17'd16, mode == 1, 1'b0);
            n_cmp++;
            if (got_data.size() != 16) begin
                n_err++;
                $display("FAIL stream_count[m%0d]: got %0d required 16", mode, got_data.size());
            end
            for (int i = 0; i < got_data.size(); i++) begin
                n_cmp++;
                if (got_data[i] !== ref_mem[i] || got_sop[i] != (i == 0) || got_eop[i] != (i == 15)) begin
                    n_err++;
                    $display("FAIL stream_beat[m%0d][%0d]: got data=%0h sop=%0d eop=%0d required data=%0h sop=%0d eop=%0d",
                             mode, i, got_data[i], got_sop[i], got_eop[i], ref_mem[i], i == 0, i == 15);
                end
            end
            n_cmp++;
            if (first_valid_cyc != 2) begin
                n_err++;
                $display("FAIL first_beat_latency[m%0d]: got %0d required 2", mode, first_valid_cyc);
            end
            n_cmp++;
            if (done_cyc != eop_hs_cyc + 1 || done_count != 1) begin
                n_err++;
                $display("FAIL scan_done_timing[m%0d]: got cycle %0d count %0d required cycle %0d count 1",
                         mode, done_cyc, done_count, eop_hs_cyc + 1);
            end
            n_cmp++;
            if (stall_err != 0) begin
                n_err++;
                $display("FAIL stall_stable[m%0d]: got %0d changes required 0", mode, stall_err);
            end
            n_cmp++;
            if (busy_at1 != 1 || busy_at_done != 0) begin
                n_err++;
                $display("FAIL busy_flag[m%0d]: got %0d/%0d required 1/0", mode, busy_at1, busy_at_done);
            end
            if (mode == 0) begin
                n_cmp++;
                if (eop_hs_cyc != 17) begin
                    n_err++;
                    $display("FAIL full_throughput: got eop at %0d required 17", eop_hs_cyc);
                end
            end
        end
    endtask

    task automatic test_wrap;
        int idx;
        avl_write(16'hFFFE, 8'($urandom), 1'b1, 1'b1);
        avl_write(16'hFFFF, 8'($urandom), 1'b1, 1'b1);
        avl_write(16'h0000, 8'($urandom), 1'b1, 1'b1);
        avl_write(16'h0001, 8'($urandom), 1'b1, 1'b1);
        run_scan(16'hFFFE, 17'd4, 1'b1, 1'b0);
        n_cmp++;
        if (got_data.size() != 4) begin
            n_err++;
            $display("FAIL wrap_count: got %0d required 4", got_data.size());
        end
        for (int i = 0; i < got_data.size(); i++) begin
            idx = (32'hFFFE + i) % DEPTH;
            n_cmp++;
            if (got_data[i] !== ref_mem[idx]) begin
                n_err++;
                $display("FAIL wrap_beat[%0d]: got %0h required %0h (addr %0h)", i, got_data[i], ref_mem[idx], idx);
            end
        end
    endtask

    task automatic test_edges;
        logic [15:0] b;
        logic [7:0] old_d, new_d, d;
        logic v, va;
        run_scan(16'h0003, 17'd0, 1'b0, 1'b0);
        n_cmp++;
        if (done_cyc != 1 || done_count != 1 || first_valid_cyc != -1 || got_data.size() != 0) begin
            n_err++;
            $display("FAIL len0: got done_cyc=%0d count=%0d first_valid=%0d beats=%0d required 1/1/-1/0",
                     done_cyc, done_count, first_valid_cyc, got_data.size());
        end
        b = 16'($urandom_range(0, 15));
        run_scan(b, 17'd1, 1'b1, 1'b0);
        n_cmp++;
        if (got_data.size() != 1 || got_data[0] !== ref_mem[b] || !got_sop[0] || !got_eop[0]) begin
            n_err++;
            $display("FAIL len1: got beats=%0d data=%0h required beats=1 data=%0h sop=eop=1",
                     got_data.size(), got_data.size() > 0 ? got_data[0] : 8'h0, ref_mem[b]);
        end
        run_scan(16'h0000, 17'd16, 1'b0, 1'b1);
        n_cmp++;
        if (got_data.size() != 16 || done_count != 1) begin
            n_err++;
            $display("FAIL start_while_busy_count: got beats=%0d done=%0d required 16/1", got_data.size(), done_count);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== ref_mem[i]) begin
                n_err++;
                $display("FAIL start_while_busy_beat[%0d]: got %0h required %0h", i, got_data[i], ref_mem[i]);
            end
        end
        // Port-A write to the word port B reads in the start cycle: stream sees the old word.
        b = 16'h2000 + 16'($urandom_range(0, 255));
        old_d = 8'($urandom);
        new_d = ~old_d;
        avl_write(b, old_d, 1'b1, 1'b1);
        s_chipselect = 1; s_write = 1; s_address = b; s_writedata = new_d; s_byteenable = 1; wr_enable = 1;
        run_scan(b, 17'd1, 1'b0, 1'b0);
        ref_mem[b] = new_d;
        n_cmp++;
        if (got_data.size() != 1 || got_data[0] !== old_d) begin
            n_err++;
            $display("FAIL rdw_old_data: got beats=%0d data=%0h required 1 beat data=%0h",
                     got_data.size(), got_data.size() > 0 ? got_data[0] : 8'h0, old_d);
        end
        avl_read(b, v, d, va);
        n_cmp++;
        if (d !== new_d) begin
            n_err++;
            $display("FAIL rdw_write_landed: got %0h required %0h", d, new_d);
        end
    endtask

    task automatic test_reset_mid_scan;
        int done_during;
        scan_base = 16'h0000; scan_len = 17'd16; scan_start = 1; st_ready = 1;
        step;
        scan_start = 0;
        for (int c = 1; c < 7; c++) step;
        n_cmp++;
        if (st_valid !== 1'b1 || st_data !== ref_mem[5]) begin
            n_err++;
            $display("FAIL beat5_presented: got valid=%b data=%0h required valid=1 data=%0h", st_valid, st_data, ref_mem[5]);
        end
        #2 reset_n = 0;
        #1;
        n_cmp++;
        if ({s_readdata, s_readdatavalid, scan_busy, scan_done, st_data, st_valid, st_sop, st_eop} !== '0) begin
            n_err++;
            $display("FAIL async_reset_outputs: got %0h required 0",
                     {s_readdata, s_readdatavalid, scan_busy, scan_done, st_data, st_valid, st_sop, st_eop});
        end
        done_during = 0;
        for (int c = 0; c < 3; c++) begin
            step;
            if (scan_done) done_during++;
        end
        reset_n = 1;
        for (int c = 0; c < 3; c++) begin
            step;
            if (scan_done || st_valid || scan_busy) done_during++;
        end
        n_cmp++;
        if (done_during != 0) begin
            n_err++;
            $display("FAIL reset_no_done: got %0d activity cycles required 0", done_during);
        end
        run_scan(16'h0000, 17'd16, 1'b1, 1'b0);
        n_cmp++;
        if (got_data.size() != 16 || done_count != 1) begin
            n_err++;
            $display("FAIL rescan_count: got beats=%0d done=%0d required 16/1", got_data.size(), done_count);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== ref_mem[i] || got_sop[i] != (i == 0) || got_eop[i] != (i == 15)) begin
                n_err++;
                $display("FAIL rescan_beat[%0d]: got data=%0h sop=%0d eop=%0d required data=%0h",
                         i, got_data[i], got_sop[i], got_eop[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_port_a;
        test_stream;
        test_wrap;
        test_edges;
        test_reset_mid_scan;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
